// File: rtl/aclock_pkg.sv
// Shared types and BCD helpers for the multi-channel alarm clock.
package aclock_pkg;

    localparam int unsigned H1_W     = 2;
    localparam int unsigned DIG_W    = 4;
    localparam int unsigned MAX_HOUR = 23;
    localparam int unsigned MAX_MIN  = 59;
    localparam int unsigned MAX_SEC  = 59;

    typedef enum logic [1:0] {
        CH_IDLE,
        CH_RINGING,
        CH_SNOOZED
    } ch_state_e;

    typedef struct packed {
        logic [H1_W-1:0]  h1;
        logic [DIG_W-1:0] h0;
        logic [DIG_W-1:0] m1;
        logic [DIG_W-1:0] m0;
    } bcd_hm_t;

    typedef struct packed {
        bcd_hm_t          hm;
        logic [DIG_W-1:0] s1;
        logic [DIG_W-1:0] s0;
    } bcd_time_t;

    function automatic int unsigned bcd2bin(logic [DIG_W-1:0] tens, logic [DIG_W-1:0] ones);
        return 32'(tens) * 10 + 32'(ones);
    endfunction

    function automatic logic hm_valid(bcd_hm_t t);
        return (t.h0 <= 4'd9) && (t.m0 <= 4'd9) &&
               (bcd2bin(t.m1, t.m0) <= MAX_MIN) &&
               (bcd2bin(4'(t.h1), t.h0) <= MAX_HOUR);
    endfunction

    // add < 60, so at most one minute carry into the hour is possible
    function automatic bcd_hm_t hm_add_min(bcd_hm_t t, int unsigned add);
        int unsigned m;
        int unsigned h;
        bcd_hm_t     r;
        m = bcd2bin(t.m1, t.m0) + add;
        h = bcd2bin(4'(t.h1), t.h0);
        if (m > MAX_MIN) begin
            m = m - (MAX_MIN + 1);
            h = h + 1;
        end
        if (h > MAX_HOUR) h = h - (MAX_HOUR + 1);
        r.h1 = H1_W'(h / 10);
        r.h0 = DIG_W'(h % 10);
        r.m1 = DIG_W'(m / 10);
        r.m0 = DIG_W'(m % 10);
        return r;
    endfunction

endpackage

// File: rtl/aclock_multi_if.sv
// Load bus, alarm controls and time display of the alarm clock.
interface aclock_multi_if
    import aclock_pkg::*;
#(
    parameter int N_ALARMS = 4
);
    localparam int SEL_W = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1;

    logic [H1_W-1:0]     h_in1;
    logic [DIG_W-1:0]    h_in0;
    logic [DIG_W-1:0]    m_in1;
    logic [DIG_W-1:0]    m_in0;
    logic                ld_time;
    logic                ld_alarm;
    logic [SEL_W-1:0]    alarm_sel;
    logic [N_ALARMS-1:0] al_on;
    logic [N_ALARMS-1:0] stop_al;
    logic [N_ALARMS-1:0] snooze;
    logic [N_ALARMS-1:0] alarm;
    logic [H1_W-1:0]     h_out1;
    logic [DIG_W-1:0]    h_out0;
    logic [DIG_W-1:0]    m_out1;
    logic [DIG_W-1:0]    m_out0;
    logic [DIG_W-1:0]    s_out1;
    logic [DIG_W-1:0]    s_out0;
    logic                sec_tick;
    logic                ld_err;

    modport master (
        output h_in1, h_in0, m_in1, m_in0, ld_time, ld_alarm, alarm_sel,
               al_on, stop_al, snooze,
        input  alarm, h_out1, h_out0, m_out1, m_out0, s_out1, s_out0,
               sec_tick, ld_err
    );

    modport slave (
        input  h_in1, h_in0, m_in1, m_in0, ld_time, ld_alarm, alarm_sel,
               al_on, stop_al, snooze,
        output alarm, h_out1, h_out0, m_out1, m_out0, s_out1, s_out0,
               sec_tick, ld_err
    );

endinterface

// File: rtl/aclock_alarm_ch.sv
// One alarm channel: stored target, snooze target and ring/snooze state machine.
module aclock_alarm_ch
    import aclock_pkg::*;
#(
    parameter int unsigned SNOOZE_MIN = 5
) (
    input  logic      clk,
    input  logic      rst_n,
    input  bcd_time_t cur,
    input  logic      fresh,
    input  logic      ld,
    input  bcd_hm_t   ld_hm,
    input  logic      al_on,
    input  logic      stop,
    input  logic      snooze,
    output logic      ringing
);

    ch_state_e state_q, state_d;
    bcd_hm_t   alarm_q;
    bcd_hm_t   snz_q, snz_d;
    logic      at_min, hit_al, hit_sn;

    // Only a freshly ticked/loaded HH:MM:00 may match, so a held time never re-fires
    assign at_min = fresh && (cur.s1 == '0) && (cur.s0 == '0);
    assign hit_al = at_min && al_on && (cur.hm == alarm_q);
    assign hit_sn = at_min && (cur.hm == snz_q);

    always_comb begin
        state_d = state_q;
        snz_d   = snz_q;
        case (state_q)
            CH_IDLE: begin
                if (!stop && hit_al) state_d = CH_RINGING;
            end
            CH_RINGING: begin
                if (stop) begin
                    state_d = CH_IDLE;
                end else if (snooze) begin
                    state_d = CH_SNOOZED;
                    snz_d   = hm_add_min(cur.hm, SNOOZE_MIN);
                end
            end
            CH_SNOOZED: begin
                if (stop || !al_on || ld) state_d = CH_IDLE;
                else if (hit_sn)          state_d = CH_RINGING;
            end
            default: state_d = CH_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CH_IDLE;
            alarm_q <= '0;
            snz_q   <= '0;
        end else begin
            state_q <= state_d;
            snz_q   <= snz_d;
            if (ld) alarm_q <= ld_hm;
        end
    end

    assign ringing = (state_q == CH_RINGING);

endmodule

// File: rtl/aclock_multi.sv
// BCD real-time clock with prescaler, validated loads and N alarm channels.
module aclock_multi
    import aclock_pkg::*;
#(
    parameter int CLK_DIV    = 10,
    parameter int N_ALARMS   = 4,
    parameter int SNOOZE_MIN = 5
) (
    input  logic           clk,
    input  logic           reset_n,
    aclock_multi_if.slave  bus
);

    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

    logic [PW-1:0]       presc;
    bcd_time_t           t_q, t_inc;
    logic                fresh;
    logic                ld_err_q;
    logic                sec_tick;
    bcd_hm_t             in_hm;
    logic                in_ok, sel_ok, time_ok, alarm_ok;
    logic [N_ALARMS-1:0] ch_ld;
    logic [N_ALARMS-1:0] ringing;

    assign in_hm    = '{h1: bus.h_in1, h0: bus.h_in0, m1: bus.m_in1, m0: bus.m_in0};
    assign in_ok    = hm_valid(in_hm);
    assign sel_ok   = 32'(bus.alarm_sel) < 32'(N_ALARMS);
    assign time_ok  = bus.ld_time && in_ok;
    assign alarm_ok = bus.ld_alarm && in_ok && sel_ok;
    assign sec_tick = (presc == PRESC_MAX);

    always_comb begin
        ch_ld = '0;
        for (int k = 0; k < N_ALARMS; k++)
            ch_ld[k] = alarm_ok && (32'(bus.alarm_sel) == 32'(k));
    end

    // Ripple-carry through the BCD digits: s0 -> s1 -> m0 -> m1 -> hours
    always_comb begin
        t_inc = t_q;
        if (t_q.s0 != 4'd9) begin
            t_inc.s0 = t_q.s0 + 4'd1;
        end else if (bcd2bin(t_q.s1, t_q.s0) != MAX_SEC) begin
            t_inc.s0 = '0;
            t_inc.s1 = t_q.s1 + 4'd1;
        end else begin
            t_inc.s0 = '0;
            t_inc.s1 = '0;
            if (t_q.hm.m0 != 4'd9) begin
                t_inc.hm.m0 = t_q.hm.m0 + 4'd1;
            end else if (bcd2bin(t_q.hm.m1, t_q.hm.m0) != MAX_MIN) begin
                t_inc.hm.m0 = '0;
                t_inc.hm.m1 = t_q.hm.m1 + 4'd1;
            end else begin
                t_inc.hm.m0 = '0;
                t_inc.hm.m1 = '0;
                if (bcd2bin(4'(t_q.hm.h1), t_q.hm.h0) == MAX_HOUR) begin
                    t_inc.hm.h1 = '0;
                    t_inc.hm.h0 = '0;
                end else if (t_q.hm.h0 != 4'd9) begin
                    t_inc.hm.h0 = t_q.hm.h0 + 4'd1;
                end else begin
                    t_inc.hm.h0 = '0;
                    t_inc.hm.h1 = t_q.hm.h1 + 2'd1;
                end
            end
        end
    end

    // A valid time load swallows a coincident tick and restarts the second
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc    <= '0;
            t_q      <= '0;
            fresh    <= 1'b0;
            ld_err_q <= 1'b0;
        end else begin
            fresh    <= 1'b0;
            ld_err_q <= (bus.ld_time && !in_ok) || (bus.ld_alarm && !(in_ok && sel_ok));
            if (time_ok) begin
                t_q   <= '{hm: in_hm, s1: '0, s0: '0};
                presc <= '0;
                fresh <= 1'b1;
            end else if (sec_tick) begin
                t_q   <= t_inc;
                presc <= '0;
                fresh <= 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < N_ALARMS; k++) begin : g_ch
        aclock_alarm_ch #(.SNOOZE_MIN(SNOOZE_MIN)) u_ch (
            .clk     (clk),
            .rst_n   (reset_n),
            .cur     (t_q),
            .fresh   (fresh),
            .ld      (ch_ld[k]),
            .ld_hm   (in_hm),
            .al_on   (bus.al_on[k]),
            .stop    (bus.stop_al[k]),
            .snooze  (bus.snooze[k]),
            .ringing (ringing[k])
        );
    end

    assign bus.alarm    = ringing;
    assign bus.h_out1   = t_q.hm.h1;
    assign bus.h_out0   = t_q.hm.h0;
    assign bus.m_out1   = t_q.hm.m1;
    assign bus.m_out0   = t_q.hm.m0;
    assign bus.s_out1   = t_q.s1;
    assign bus.s_out0   = t_q.s0;
    assign bus.sec_tick = sec_tick;
    assign bus.ld_err   = ld_err_q;

endmodule
